mem_axis_arbiter: RTL and testbench
===================================

Name: mem_axis_arbiter

Overview:
- Shares one 128-bit memory request/response AXI-stream pair between two requesters, client 0 and client 1. Typical clients are the wrapped processor and a frame-buffer/DMA engine.
- Request side: each transaction is one header beat (tuser=1) followed, for writes only, by stream_length data beats. The arbiter forwards each transaction atomically.
- Header beat layout: channel_update {addr[26:0], stream_length[26:0], wen} packed in data[54:0].
- Response side: read responses come back in request order. The arbiter routes each response beat to the owning client using an in-order route FIFO.

Parameters:
- ROUTE_DEPTH, 4, maximum outstanding reads (route FIFO entries); power of two, ≥2.
- LEN_W, 27, width of the stream_length field and of the beat counters.

Ports:
- clk_in  in  1  clock
- rst_in  in  1  synchronous active-high reset
- cN_req_axis_data  in  128  client N request beat (N = 0, 1)
- cN_req_axis_tuser  in  1  client N header marker
- cN_req_axis_valid  in  1  client N request valid
- cN_req_axis_ready  out  1  client N request accepted
- cN_resp_axis_data  out  128  client N response beat
- cN_resp_axis_tuser  out  1  client N response tuser (passthrough)
- cN_resp_axis_valid  out  1  client N response valid
- cN_resp_axis_ready  in  1  client N response ready
- mem_req_axis_data  out  128  shared request beat
- mem_req_axis_tuser  out  1  shared header marker
- mem_req_axis_valid  out  1  shared request valid
- mem_req_axis_ready  in  1  shared request ready
- mem_resp_axis_data  in  128  shared response beat
- mem_resp_axis_tuser  in  1  shared response tuser
- mem_resp_axis_valid  in  1  shared response valid
- mem_resp_axis_ready  out  1  shared response ready

Behaviour:
- Reset (synchronous, rst_in high at posedge):
  - state=IDLE, rr_last=1 (client 0 wins the first tie), route FIFO empty, beat counters 0.
  - All valid/ready outputs 0; all data outputs 0.
  - Reset mid-transaction abandons the transaction. No further beats are forwarded and queued routes are discarded.
- Request FSM:
  - IDLE:
    - A client is eligible when its valid=1 and tuser=1.
    - If both are eligible, grant the client that is not rr_last.
    - Register grant and rr_last, then go to HDR. Arbitration costs one cycle; no ready is asserted in IDLE.
  - HDR:
    - The granted client's data/tuser/valid pass combinationally to mem_req. The granted client's ready = mem_req_axis_ready.
    - For a read header (wen=0), the beat is gated: mem_req_axis_valid=0 while the route FIFO is full.
    - On accept with wen=0: push {grant, stream_length} into the route FIFO, then go to IDLE.
    - On accept with wen=1 and stream_length>0: load wcnt=stream_length, then go to WDATA.
    - On accept with wen=1 and stream_length=0: go to IDLE.
  - WDATA:
    - Granted client passes through. Its tuser is forwarded as-is; the arbiter does not check it.
    - Each accepted beat decrements wcnt. The beat accepted at wcnt==1 returns the FSM to IDLE.
  - The non-granted client's ready is always 0.
  - In IDLE, a client presenting valid with tuser=0 is not accepted (ready stays 0) and is never granted.
- Response routing:
  - The route FIFO head gives {id, len}.
  - mem_resp_axis_ready = FIFO non-empty and c[id]_resp_axis_ready.
  - c[id]_resp_axis_valid = FIFO non-empty and mem_resp_axis_valid. Data and tuser pass through combinationally. The other client's valid is 0.
  - rcnt counts accepted beats of the head entry. On the beat where rcnt==len-1, pop the head and clear rcnt.
  - A read with len=0 pops the FIFO the cycle after it reaches the head, with no beats transferred.
  - Writes generate no response entry.
  - While the FIFO is empty, mem_resp_axis_ready=0.
- FIFO boundary conditions:
  - Full and empty are computed from the registered count.
  - Push and pop in the same cycle are legal; the count is unchanged.
  - No push is allowed when full, even if a pop happens in the same cycle.
- Ordering: responses return in header-accept order across both clients. Each client sees its own reads in issue order.

Optional Feature:
- Macro: MEM_ARB_PERF_EN.
- Defined:
  - Adds outputs perf_c0_grants_out[31:0], perf_c1_grants_out[31:0] and perf_route_full_out[31:0].
  - perf_cN_grants_out increments on each grant to client N.
  - perf_route_full_out counts cycles in HDR with a read header blocked by a full FIFO.
  - All three counters wrap at 2^32 and reset to 0.
- Undefined: these ports and counters do not exist; all other behaviour is identical.

Test Plan:
- Single read: c0 sends header addr=0x100, len=4, wen=0; memory returns beats 0xA..0xD.
  - Expect exactly one header on mem_req, four beats on c0_resp, c1_resp_axis_valid=0 throughout, FIFO empty afterwards.
- Simultaneous headers: both clients post read headers with len=4 on the same cycle, repeated three times.
  - Expect grants in order c0, c1, c0, c1, c0, c1.
  - Response beats route to c0, c1, c0, c1, ...; each client receives exactly 12 beats.
- Write atomicity: c0 sends a write header with len=4 plus 4 data beats; c1 posts a read header during c0's beat 2.
  - Expect all four c0 data beats contiguous on mem_req before c1's header appears.
  - mem_req_axis_ready held low for 3 cycles mid-burst: no beat lost or duplicated.
- FIFO full (ROUTE_DEPTH=4): issue 5 reads with memory response ready withheld.
  - Expect the fifth header to stay valid on the client with mem_req_axis_valid=0.
  - The fifth header is accepted in the cycle after the first read's last beat pops.
- Backpressure: c1 holds c1_resp_axis_ready=0 for 10 cycles mid-response.
  - Expect mem_resp_axis_ready=0 for those cycles and data on c1_resp held stable.
- Reset mid-write: assert rst_in after 2 of 4 write beats.
  - Expect all valid/ready outputs 0 the next cycle, FSM in IDLE, and the next header granted to c0 on a tie.

Source files
------------

// File: rtl/mem_axis_arbiter.sv
// mem_axis_arbiter
// Shares one 128-bit memory request/response AXI-stream pair between two
// clients. Request transactions (one header beat with tuser=1, followed by
// stream_length data beats for writes) are forwarded atomically under
// round-robin arbitration. Read responses come back in request order and are
// steered to the owning client by an in-order route FIFO.
//
// Header beat: data[54:0] = {addr[26:0], stream_length[26:0], wen}.
//
// Ports:
//   clk_in, rst_in                 clock, synchronous active-high reset
//   cN_req_axis_*  (N = 0, 1)      client request streams (data/tuser/valid in, ready out)
//   cN_resp_axis_* (N = 0, 1)      client response streams (data/tuser/valid out, ready in)
//   mem_req_axis_*                 shared request stream towards memory
//   mem_resp_axis_*                shared response stream from memory
//   perf_*_out                     performance counters, present only when
//                                  MEM_ARB_PERF_EN is defined
//
// Parameters:
//   ROUTE_DEPTH  outstanding reads tracked (power of two, >= 2)
//   LEN_W        width of stream_length and of the beat counters
module mem_axis_arbiter #(
    parameter int ROUTE_DEPTH = 4,
    parameter int LEN_W       = 27
) (
    input  logic         clk_in,
    input  logic         rst_in,
    input  logic [127:0] c0_req_axis_data,
    input  logic         c0_req_axis_tuser,
    input  logic         c0_req_axis_valid,
    output logic         c0_req_axis_ready,
    input  logic [127:0] c1_req_axis_data,
    input  logic         c1_req_axis_tuser,
    input  logic         c1_req_axis_valid,
    output logic         c1_req_axis_ready,
    output logic [127:0] c0_resp_axis_data,
    output logic         c0_resp_axis_tuser,
    output logic         c0_resp_axis_valid,
    input  logic         c0_resp_axis_ready,
    output logic [127:0] c1_resp_axis_data,
    output logic         c1_resp_axis_tuser,
    output logic         c1_resp_axis_valid,
    input  logic         c1_resp_axis_ready,
    output logic [127:0] mem_req_axis_data,
    output logic         mem_req_axis_tuser,
    output logic         mem_req_axis_valid,
    input  logic         mem_req_axis_ready,
    input  logic [127:0] mem_resp_axis_data,
    input  logic         mem_resp_axis_tuser,
    input  logic         mem_resp_axis_valid,
    output logic         mem_resp_axis_ready
`ifdef MEM_ARB_PERF_EN
    ,
    output logic [31:0]  perf_c0_grants_out,
    output logic [31:0]  perf_c1_grants_out,
    output logic [31:0]  perf_route_full_out
`endif
);
    localparam int PTR_W = $clog2(ROUTE_DEPTH);
    localparam logic [PTR_W:0] DEPTH_CNT = ROUTE_DEPTH[PTR_W:0];

    typedef enum logic [1:0] {IDLE, HDR, WDATA} state_t;

    state_t           state_q;
    logic             grant_q;
    logic             rr_last_q;
    logic [LEN_W-1:0] wcnt_q;

    // Per-client views of the ports so the steering logic can be generated.
    logic [127:0] req_data   [2];
    logic         req_tuser  [2];
    logic         req_valid  [2];
    logic         req_ready  [2];
    logic [127:0] resp_data  [2];
    logic         resp_tuser [2];
    logic         resp_valid [2];
    logic         resp_ready [2];

    assign req_data[0]  = c0_req_axis_data;
    assign req_data[1]  = c1_req_axis_data;
    assign req_tuser[0] = c0_req_axis_tuser;
    assign req_tuser[1] = c1_req_axis_tuser;
    assign req_valid[0] = c0_req_axis_valid;
    assign req_valid[1] = c1_req_axis_valid;
    assign resp_ready[0] = c0_resp_axis_ready;
    assign resp_ready[1] = c1_resp_axis_ready;

    assign c0_req_axis_ready  = req_ready[0];
    assign c1_req_axis_ready  = req_ready[1];
    assign c0_resp_axis_data  = resp_data[0];
    assign c1_resp_axis_data  = resp_data[1];
    assign c0_resp_axis_tuser = resp_tuser[0];
    assign c1_resp_axis_tuser = resp_tuser[1];
    assign c0_resp_axis_valid = resp_valid[0];
    assign c1_resp_axis_valid = resp_valid[1];

    // Route FIFO state
    logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
    logic [PTR_W:0]   cnt_q, cnt_d;
    logic             id_mem  [ROUTE_DEPTH];
    logic [LEN_W-1:0] len_mem [ROUTE_DEPTH];
    logic [LEN_W-1:0] rcnt_q;
    logic             fifo_full, fifo_empty, push, pop;
    logic             head_id;
    logic [LEN_W-1:0] head_len;
    logic             resp_live, resp_accept;

    // Request path
    logic [127:0]     sel_data;
    logic             sel_tuser, sel_valid;
    logic             fwd, hdr_wen, blocked, req_accept;
    logic [LEN_W-1:0] hdr_len;
    logic             elig0, elig1, arb_pick;

    assign sel_data  = req_data[grant_q];
    assign sel_tuser = req_tuser[grant_q];
    assign sel_valid = req_valid[grant_q];
    assign fwd       = (state_q != IDLE);
    assign hdr_wen   = sel_data[0];
    assign hdr_len   = sel_data[LEN_W:1];

    // A read header may only go out if its route can be recorded; the client
    // ready is gated too so the client never sees an accept memory did not.
    assign blocked = (state_q == HDR) && !hdr_wen && fifo_full;

    assign mem_req_axis_valid = fwd && sel_valid && !blocked;
    assign mem_req_axis_data  = fwd ? sel_data : '0;
    assign mem_req_axis_tuser = fwd && sel_tuser;
    assign req_accept         = mem_req_axis_valid && mem_req_axis_ready;

    assign elig0 = c0_req_axis_valid && c0_req_axis_tuser;
    assign elig1 = c1_req_axis_valid && c1_req_axis_tuser;
    // On a tie the client that did not win last time gets the grant.
    assign arb_pick = (elig0 && elig1) ? ~rr_last_q : elig1;

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state_q   <= IDLE;
            grant_q   <= 1'b0;
            rr_last_q <= 1'b1;
            wcnt_q    <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (elig0 || elig1) begin
                        grant_q   <= arb_pick;
                        rr_last_q <= arb_pick;
                        state_q   <= HDR;
                    end
                end
                HDR: begin
                    if (req_accept) begin
                        if (!hdr_wen || hdr_len == '0) begin
                            state_q <= IDLE;
                        end else begin
                            wcnt_q  <= hdr_len;
                            state_q <= WDATA;
                        end
                    end
                end
                WDATA: begin
                    if (req_accept) begin
                        wcnt_q <= wcnt_q - LEN_W'(1);
                        if (wcnt_q == LEN_W'(1)) state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // Route FIFO: full/empty come from the registered count only.
    assign fifo_full  = (cnt_q == DEPTH_CNT);
    assign fifo_empty = (cnt_q == '0);
    assign head_id    = id_mem[rd_ptr_q];
    assign head_len   = len_mem[rd_ptr_q];
    assign push       = (state_q == HDR) && req_accept && !hdr_wen;

    // A zero-length read owns no beats: it is retired without opening the
    // response path so a stray beat cannot be swallowed on its behalf.
    assign resp_live           = !fifo_empty && (head_len != '0);
    assign mem_resp_axis_ready = resp_live && resp_ready[head_id];
    assign resp_accept         = mem_resp_axis_valid && mem_resp_axis_ready;
    assign pop = !fifo_empty &&
                 ((head_len == '0) || (resp_accept && rcnt_q == head_len - LEN_W'(1)));

    always_comb begin
        cnt_d = cnt_q;
        if (push && !pop)      cnt_d = cnt_q + 1'b1;
        else if (pop && !push) cnt_d = cnt_q - 1'b1;
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
            rcnt_q   <= '0;
        end else begin
            cnt_q <= cnt_d;
            if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
                rcnt_q   <= '0;
            end else if (resp_accept) begin
                rcnt_q <= rcnt_q + LEN_W'(1);
            end
        end
    end

    always_ff @(posedge clk_in) begin
        if (push) begin
            id_mem[wr_ptr_q]  <= grant_q;
            len_mem[wr_ptr_q] <= hdr_len;
        end
    end

    for (genvar gi = 0; gi < 2; gi++) begin : g_client
        logic own;
        assign own            = resp_live && (head_id == 1'(gi));
        assign req_ready[gi]  = fwd && (grant_q == 1'(gi)) && mem_req_axis_ready && !blocked;
        assign resp_valid[gi] = own && mem_resp_axis_valid;
        assign resp_data[gi]  = own ? mem_resp_axis_data : '0;
        assign resp_tuser[gi] = own && mem_resp_axis_tuser;
    end

`ifdef MEM_ARB_PERF_EN
    logic [31:0] perf_c0_q, perf_c1_q, perf_full_q;

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            perf_c0_q   <= '0;
            perf_c1_q   <= '0;
            perf_full_q <= '0;
        end else begin
            if (state_q == IDLE && (elig0 || elig1)) begin
                if (arb_pick) perf_c1_q <= perf_c1_q + 32'd1;
                else          perf_c0_q <= perf_c0_q + 32'd1;
            end
            if (blocked && sel_valid) perf_full_q <= perf_full_q + 32'd1;
        end
    end

    assign perf_c0_grants_out  = perf_c0_q;
    assign perf_c1_grants_out  = perf_c1_q;
    assign perf_route_full_out = perf_full_q;
`endif
endmodule

// File: tb/tb_mem_axis_arbiter.sv
// Directed testbench for mem_axis_arbiter: reset state, single read,
// round-robin ties, write atomicity under backpressure, route FIFO full,
// response backpressure and reset in the middle of a write.
`timescale 1ns/1ps
module tb_mem_axis_arbiter;
    logic clk_in = 1'b0;
    always #5 clk_in = ~clk_in;

    logic         rst_in;
    logic [127:0] c0_req_axis_data, c1_req_axis_data;
    logic         c0_req_axis_tuser, c1_req_axis_tuser;
    logic         c0_req_axis_valid, c1_req_axis_valid;
    logic         c0_req_axis_ready, c1_req_axis_ready;
    logic [127:0] c0_resp_axis_data, c1_resp_axis_data;
    logic         c0_resp_axis_tuser, c1_resp_axis_tuser;
    logic         c0_resp_axis_valid, c1_resp_axis_valid;
    logic         c0_resp_axis_ready, c1_resp_axis_ready;
    logic [127:0] mem_req_axis_data;
    logic         mem_req_axis_tuser, mem_req_axis_valid, mem_req_axis_ready;
    logic [127:0] mem_resp_axis_data;
    logic         mem_resp_axis_tuser, mem_resp_axis_valid, mem_resp_axis_ready;
`ifdef MEM_ARB_PERF_EN
    logic [31:0]  perf_c0_grants_out, perf_c1_grants_out, perf_route_full_out;
`endif

    mem_axis_arbiter #(.ROUTE_DEPTH(4), .LEN_W(27)) dut (
        .clk_in              (clk_in),
        .rst_in              (rst_in),
        .c0_req_axis_data    (c0_req_axis_data),
        .c0_req_axis_tuser   (c0_req_axis_tuser),
        .c0_req_axis_valid   (c0_req_axis_valid),
        .c0_req_axis_ready   (c0_req_axis_ready),
        .c1_req_axis_data    (c1_req_axis_data),
        .c1_req_axis_tuser   (c1_req_axis_tuser),
        .c1_req_axis_valid   (c1_req_axis_valid),
        .c1_req_axis_ready   (c1_req_axis_ready),
        .c0_resp_axis_data   (c0_resp_axis_data),
        .c0_resp_axis_tuser  (c0_resp_axis_tuser),
        .c0_resp_axis_valid  (c0_resp_axis_valid),
        .c0_resp_axis_ready  (c0_resp_axis_ready),
        .c1_resp_axis_data   (c1_resp_axis_data),
        .c1_resp_axis_tuser  (c1_resp_axis_tuser),
        .c1_resp_axis_valid  (c1_resp_axis_valid),
        .c1_resp_axis_ready  (c1_resp_axis_ready),
        .mem_req_axis_data   (mem_req_axis_data),
        .mem_req_axis_tuser  (mem_req_axis_tuser),
        .mem_req_axis_valid  (mem_req_axis_valid),
        .mem_req_axis_ready  (mem_req_axis_ready),
        .mem_resp_axis_data  (mem_resp_axis_data),
        .mem_resp_axis_tuser (mem_resp_axis_tuser),
        .mem_resp_axis_valid (mem_resp_axis_valid),
        .mem_resp_axis_ready (mem_resp_axis_ready)
`ifdef MEM_ARB_PERF_EN
        ,
        .perf_c0_grants_out  (perf_c0_grants_out),
        .perf_c1_grants_out  (perf_c1_grants_out),
        .perf_route_full_out (perf_route_full_out)
`endif
    );

    int vectors_applied = 0;
    int miscompares     = 0;

    task automatic chk(input string tag, input logic [128:0] obs, input logic [128:0] exp);
        vectors_applied++;
        if (obs !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end
    endtask

    // Passive monitor: logs every handshake, one line per transaction.
    logic [128:0] req_log [$];
    int           req_src [$];
    logic [127:0] c0_log  [$];
    logic [127:0] c1_log  [$];
    int           c1_valid_cycles = 0;

    always @(negedge clk_in) begin
        if (mem_req_axis_valid && mem_req_axis_ready) begin
            req_log.push_back({mem_req_axis_tuser, mem_req_axis_data});
            req_src.push_back(c1_req_axis_ready ? 1 : 0);
            $display("[%0t] mem_req  src=c%0d tuser=%0b data=%0h", $time,
                     c1_req_axis_ready ? 1 : 0, mem_req_axis_tuser, mem_req_axis_data);
        end
        if (c0_resp_axis_valid && c0_resp_axis_ready) begin
            c0_log.push_back(c0_resp_axis_data);
            $display("[%0t] c0_resp  data=%0h", $time, c0_resp_axis_data);
        end
        if (c1_resp_axis_valid && c1_resp_axis_ready) begin
            c1_log.push_back(c1_resp_axis_data);
            $display("[%0t] c1_resp  data=%0h", $time, c1_resp_axis_data);
        end
        if (c1_resp_axis_valid) c1_valid_cycles++;
    end

    function automatic logic [128:0] req_at(input int i);
        if (i < req_log.size()) return req_log[i];
        return '1;
    endfunction
    function automatic int src_at(input int i);
        if (i < req_src.size()) return req_src[i];
        return -1;
    endfunction
    function automatic logic [127:0] c0_at(input int i);
        if (i < c0_log.size()) return c0_log[i];
        return '1;
    endfunction
    function automatic logic [127:0] c1_at(input int i);
        if (i < c1_log.size()) return c1_log[i];
        return '1;
    endfunction

    function automatic logic [127:0] hdr(input logic [26:0] a, input logic [26:0] l, input logic w);
        return {73'd0, a, l, w};
    endfunction

    task automatic tick;
        @(posedge clk_in);
        #1;
    endtask

    task automatic send(input int c, input logic [127:0] d, input logic u);
        int n;
        logic rdy;
        if (c == 0) begin
            c0_req_axis_data = d; c0_req_axis_tuser = u; c0_req_axis_valid = 1'b1;
        end else begin
            c1_req_axis_data = d; c1_req_axis_tuser = u; c1_req_axis_valid = 1'b1;
        end
        n = 0;
        forever begin
            @(negedge clk_in);
            rdy = (c == 0) ? c0_req_axis_ready : c1_req_axis_ready;
            if (rdy) break;
            n++;
            if (n > 300) begin
                chk("send_timeout", {128'd0, rdy}, 129'd1);
                break;
            end
        end
        @(posedge clk_in);
        #1;
        if (c == 0) c0_req_axis_valid = 1'b0;
        else        c1_req_axis_valid = 1'b0;
    endtask

    task automatic mem_beat(input logic [127:0] d);
        int n;
        mem_resp_axis_data  = d;
        mem_resp_axis_valid = 1'b1;
        n = 0;
        forever begin
            @(negedge clk_in);
            if (mem_resp_axis_ready) break;
            n++;
            if (n > 300) begin
                chk("resp_timeout", {128'd0, mem_resp_axis_ready}, 129'd1);
                break;
            end
        end
        @(posedge clk_in);
        #1;
        mem_resp_axis_valid = 1'b0;
    endtask

    task automatic do_reset;
        rst_in = 1'b1;
        c0_req_axis_valid = 1'b0; c0_req_axis_tuser = 1'b0; c0_req_axis_data = '0;
        c1_req_axis_valid = 1'b0; c1_req_axis_tuser = 1'b0; c1_req_axis_data = '0;
        c0_resp_axis_ready = 1'b0; c1_resp_axis_ready = 1'b0;
        mem_req_axis_ready = 1'b1;
        mem_resp_axis_valid = 1'b0; mem_resp_axis_tuser = 1'b0; mem_resp_axis_data = '0;
        tick;
        tick;
        rst_in = 1'b0;
        #1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    int rb, c0b, c1b, c1v, e;

    initial begin
        // ---- reset state ----
        do_reset;
        chk("rst_mem_req_valid", {128'd0, mem_req_axis_valid}, 129'd0);
        chk("rst_mem_req_data", {1'b0, mem_req_axis_data}, 129'd0);
        chk("rst_mem_req_tuser", {128'd0, mem_req_axis_tuser}, 129'd0);
        chk("rst_c0_req_ready", {128'd0, c0_req_axis_ready}, 129'd0);
        chk("rst_c1_req_ready", {128'd0, c1_req_axis_ready}, 129'd0);
        chk("rst_c0_resp_valid", {128'd0, c0_resp_axis_valid}, 129'd0);
        chk("rst_c1_resp_valid", {128'd0, c1_resp_axis_valid}, 129'd0);
        chk("rst_c1_resp_data", {1'b0, c1_resp_axis_data}, 129'd0);
        chk("rst_mem_resp_ready", {128'd0, mem_resp_axis_ready}, 129'd0);

        // ---- single read from c0 ----
        rb = req_log.size(); c0b = c0_log.size(); c1v = c1_valid_cycles;
        c0_resp_axis_ready = 1'b1;
        c0_req_axis_data = hdr(27'h100, 27'd4, 1'b0);
        c0_req_axis_tuser = 1'b1; c0_req_axis_valid = 1'b1;
        #1;
        chk("t1_no_ready_in_idle", {128'd0, c0_req_axis_ready}, 129'd0);
        send(0, hdr(27'h100, 27'd4, 1'b0), 1'b1);
        for (int k = 0; k < 4; k++) mem_beat(128'hA + 128'(k));
        #1;
        chk("t1_hdr_count", 129'(req_log.size() - rb), 129'd1);
        chk("t1_hdr_beat", req_at(rb), {1'b1, hdr(27'h100, 27'd4, 1'b0)});
        chk("t1_resp_count", 129'(c0_log.size() - c0b), 129'd4);
        for (int k = 0; k < 4; k++)
            chk("t1_resp_beat", {1'b0, c0_at(c0b + k)}, 129'hA + 129'(k));
        chk("t1_c1_valid_cycles", 129'(c1_valid_cycles - c1v), 129'd0);
        chk("t1_fifo_empty", {128'd0, mem_resp_axis_ready}, 129'd0);

        // ---- simultaneous read headers, three rounds ----
        do_reset;
        rb = req_log.size(); c0b = c0_log.size(); c1b = c1_log.size();
        c0_resp_axis_ready = 1'b1; c1_resp_axis_ready = 1'b1;
        fork
            for (int i = 0; i < 3; i++) send(0, hdr(27'h10 + 27'(i), 27'd4, 1'b0), 1'b1);
            for (int i = 0; i < 3; i++) send(1, hdr(27'h20 + 27'(i), 27'd4, 1'b0), 1'b1);
            for (int k = 0; k < 24; k++) mem_beat(128'h1000 + 128'(k));
        join
        #1;
        chk("t2_hdr_count", 129'(req_log.size() - rb), 129'd6);
        for (int i = 0; i < 6; i++) begin
            e = ((i % 2) == 1 ? 'h20 : 'h10) + i / 2;
            chk("t2_grant_src", 129'(src_at(rb + i)), 129'(i % 2));
            chk("t2_grant_addr", {101'd0, req_at(rb + i)[54:28]}, 129'(e));
        end
        chk("t2_c0_beats", 129'(c0_log.size() - c0b), 129'd12);
        chk("t2_c1_beats", 129'(c1_log.size() - c1b), 129'd12);
        for (int k = 0; k < 12; k++) begin
            e = 'h1000 + (k / 4) * 8 + (k % 4);
            chk("t2_c0_route", {1'b0, c0_at(c0b + k)}, 129'(e));
            chk("t2_c1_route", {1'b0, c1_at(c1b + k)}, 129'(e + 4));
        end

        // ---- write atomicity with mid-burst memory backpressure ----
        do_reset;
        rb = req_log.size();
        fork
            begin
                send(0, hdr(27'h200, 27'd4, 1'b1), 1'b1);
                for (int i = 0; i < 4; i++) send(0, 128'hD0 + 128'(i), 1'b0);
            end
            begin
                repeat (5) tick;
                send(1, hdr(27'h300, 27'd2, 1'b0), 1'b1);
            end
            begin
                repeat (5) tick;
                mem_req_axis_ready = 1'b0;
                repeat (3) tick;
                mem_req_axis_ready = 1'b1;
            end
        join
        #1;
        chk("t3_beat_count", 129'(req_log.size() - rb), 129'd6);
        chk("t3_wr_hdr", req_at(rb), {1'b1, hdr(27'h200, 27'd4, 1'b1)});
        for (int i = 0; i < 4; i++)
            chk("t3_wr_data", req_at(rb + 1 + i), {1'b0, 128'hD0 + 128'(i)});
        chk("t3_c1_hdr", req_at(rb + 5), {1'b1, hdr(27'h300, 27'd2, 1'b0)});
        chk("t3_c1_src", 129'(src_at(rb + 5)), 129'd1);

        // ---- route FIFO full ----
        do_reset;
        rb = req_log.size(); c0b = c0_log.size();
        c0_resp_axis_ready = 1'b1;
        for (int i = 0; i < 4; i++) send(0, hdr(27'h40 + 27'(i), 27'd2, 1'b0), 1'b1);
        c0_req_axis_data = hdr(27'h44, 27'd2, 1'b0);
        c0_req_axis_tuser = 1'b1; c0_req_axis_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick;
            chk("t4_full_gated_valid", {128'd0, mem_req_axis_valid}, 129'd0);
            chk("t4_full_gated_ready", {128'd0, c0_req_axis_ready}, 129'd0);
        end
        mem_resp_axis_data = 128'h51; mem_resp_axis_valid = 1'b1;
        #1;
        chk("t4_resp_ready", {128'd0, mem_resp_axis_ready}, 129'd1);
        tick;
        mem_resp_axis_data = 128'h52;
        #1;
        chk("t4_pop_cycle_still_full", {128'd0, mem_req_axis_valid}, 129'd0);
        tick;
        mem_resp_axis_valid = 1'b0;
        #1;
        chk("t4_after_pop_valid", {128'd0, mem_req_axis_valid}, 129'd1);
        chk("t4_after_pop_ready", {128'd0, c0_req_axis_ready}, 129'd1);
        tick;
        c0_req_axis_valid = 1'b0;
        #1;
        chk("t4_hdr_count", 129'(req_log.size() - rb), 129'd5);
        chk("t4_fifth_hdr", req_at(rb + 4), {1'b1, hdr(27'h44, 27'd2, 1'b0)});
        chk("t4_resp0", {1'b0, c0_at(c0b)}, 129'h51);
        chk("t4_resp1", {1'b0, c0_at(c0b + 1)}, 129'h52);

        // ---- response backpressure on c1 ----
        do_reset;
        c1b = c1_log.size();
        c1_resp_axis_ready = 1'b1;
        send(1, hdr(27'h60, 27'd4, 1'b0), 1'b1);
        mem_beat(128'h61);
        mem_beat(128'h62);
        c1_resp_axis_ready = 1'b0;
        mem_resp_axis_data = 128'h63; mem_resp_axis_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            #1;
            chk("t5_bp_mem_ready", {128'd0, mem_resp_axis_ready}, 129'd0);
            chk("t5_bp_c1_data", {1'b0, c1_resp_axis_data}, 129'h63);
            chk("t5_bp_c1_valid", {128'd0, c1_resp_axis_valid}, 129'd1);
            tick;
        end
        c1_resp_axis_ready = 1'b1;
        mem_beat(128'h63);
        mem_beat(128'h64);
        #1;
        chk("t5_c1_beats", 129'(c1_log.size() - c1b), 129'd4);
        chk("t5_c1_beat2", {1'b0, c1_at(c1b + 2)}, 129'h63);
        chk("t5_c1_beat3", {1'b0, c1_at(c1b + 3)}, 129'h64);
        chk("t5_fifo_empty", {128'd0, mem_resp_axis_ready}, 129'd0);

        // ---- reset in the middle of a write ----
        do_reset;
        send(0, hdr(27'h700, 27'd4, 1'b1), 1'b1);
        send(0, 128'hE0, 1'b0);
        send(0, 128'hE1, 1'b0);
        c0_req_axis_data = 128'hE2; c0_req_axis_tuser = 1'b0; c0_req_axis_valid = 1'b1;
        rst_in = 1'b1;
        tick;
        rst_in = 1'b0;
        #1;
        chk("t6_mem_req_valid", {128'd0, mem_req_axis_valid}, 129'd0);
        chk("t6_c0_req_ready", {128'd0, c0_req_axis_ready}, 129'd0);
        chk("t6_c1_req_ready", {128'd0, c1_req_axis_ready}, 129'd0);
        chk("t6_mem_resp_ready", {128'd0, mem_resp_axis_ready}, 129'd0);
        chk("t6_mem_req_data", {1'b0, mem_req_axis_data}, 129'd0);
        tick;
        chk("t6_data_beat_not_granted", {128'd0, c0_req_axis_ready}, 129'd0);
        chk("t6_idle_valid", {128'd0, mem_req_axis_valid}, 129'd0);
        c0_req_axis_valid = 1'b0;
        rb = req_log.size();
        fork
            send(0, hdr(27'h800, 27'd1, 1'b0), 1'b1);
            send(1, hdr(27'h900, 27'd1, 1'b0), 1'b1);
        join
        #1;
        chk("t6_tie_src", 129'(src_at(rb)), 129'd0);
        chk("t6_tie_hdr", req_at(rb), {1'b1, hdr(27'h800, 27'd1, 1'b0)});
        chk("t6_second_src", 129'(src_at(rb + 1)), 129'd1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors_applied, miscompares);
        $finish;
    end
endmodule
